axil_hc_regbank_slave: RTL

AXI-Lite responder that terminates a holy core `axi_lite_if` master port on a bank of 32-bit read/write registers. It sits at the far end of the AXI-Lite path, behind the core or behind a PULP-to-holy-core passthrough, and serves as a peripheral register block and as a deterministic slave model for SoC benches. Write and read channels run independent state machines. Latency is programmable, and out-of-range accesses return SLVERR.

---
 rtl/axil_hc_regbank_slave_if.sv | 45 ++++
 rtl/axil_hc_regbank_slave.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/axil_hc_regbank_slave_if.sv
// AXI-Lite bundle: 32-bit address/data, byte strobes,
// and 2-bit responses. Each channel uses a valid/ready handshake.
interface axi_lite_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid,
    output wdata, wstrb, wvalid,
    output bready,
    output araddr, arvalid,
    output rready,
    input  awready, wready,
    input  bresp, bvalid,
    input  arready,
    input  rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid,
    input  wdata, wstrb, wvalid,
    input  bready,
    input  araddr, arvalid,
    input  rready,
    output awready, wready,
    output bresp, bvalid,
    output arready,
    output rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_hc_regbank_slave.sv
// AXI-Lite register bank slave with independent write/read FSMs,
// programmable response latency and SLVERR on out-of-range access.
module axil_hc_regbank_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          N_REGS      = 16,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  axi_lite_if.slave            s_axil,
  output logic [N_REGS*32-1:0] regs_o
);

  localparam int          IW     = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam logic [32:0] SPAN   = 33'(4 * N_REGS);
  localparam logic [3:0]  WLAST  = 4'(WAIT_CYCLES - 1);
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DELAY,
    W_RESP
  } wst_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_DELAY,
    R_RESP
  } rst_e;

  function automatic logic hit(input logic [31:0] a);
    logic [32:0] off;
    off = {1'b0, a} - {1'b0, BASE_ADDR};
    return off < SPAN;
  endfunction

  function automatic logic [IW-1:0] idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return IW'(off >> 2);
  endfunction

  logic [31:0] regs_q [N_REGS];

  wst_e        w_st_q, w_st_d;
  logic [3:0]  w_cnt_q, w_cnt_d;
  logic        aw_held_q, w_held_q;
  logic [31:0] awaddr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic [1:0]  bresp_q;

  rst_e        r_st_q, r_st_d;
  logic [3:0]  r_cnt_q, r_cnt_d;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;

  logic          aw_take, w_take, w_commit;
  logic [31:0]   waddr, wdat;
  logic [3:0]    wstb;
  logic          w_hit;
  logic [IW-1:0] w_idx;
  logic          r_take, r_hit;
  logic [IW-1:0] r_idx;

  // AW and W are captured independently; commit needs both.
  always_comb begin
    aw_take  = (w_st_q == W_IDLE) && !aw_held_q && s_axil.awvalid;
    w_take   = (w_st_q == W_IDLE) && !w_held_q && s_axil.wvalid;
    w_commit = (w_st_q == W_IDLE) &&
               (aw_held_q || aw_take) &&
               (w_held_q || w_take);
    waddr    = aw_held_q ? awaddr_q : s_axil.awaddr;
    wdat     = w_held_q ? wdata_q : s_axil.wdata;
    wstb     = w_held_q ? wstrb_q : s_axil.wstrb;
    w_hit    = hit(waddr);
    w_idx    = idx(waddr);
    r_take   = (r_st_q == R_IDLE) && s_axil.arvalid;
    r_hit    = hit(s_axil.araddr);
    r_idx    = idx(s_axil.araddr);
  end

  always_comb begin
    w_st_d  = w_st_q;
    w_cnt_d = w_cnt_q;
    unique case (w_st_q)
      W_IDLE: begin
        if (w_commit) begin
          w_cnt_d = '0;
          w_st_d  = (WAIT_CYCLES > 0) ? W_DELAY : W_RESP;
        end
      end
      W_DELAY: begin
        if (w_cnt_q == WLAST) w_st_d = W_RESP;
        else w_cnt_d = w_cnt_q + 4'd1;
      end
      W_RESP: begin
        if (s_axil.bready) w_st_d = W_IDLE;
      end
      default: w_st_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_st_d  = r_st_q;
    r_cnt_d = r_cnt_q;
    unique case (r_st_q)
      R_IDLE: begin
        if (r_take) begin
          r_cnt_d = '0;
          r_st_d  = (WAIT_CYCLES > 0) ? R_DELAY : R_RESP;
        end
      end
      R_DELAY: begin
        if (r_cnt_q == WLAST) r_st_d = R_RESP;
        else r_cnt_d = r_cnt_q + 4'd1;
      end
      R_RESP: begin
        if (s_axil.rready) r_st_d = R_IDLE;
      end
      default: r_st_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_st_q  <= W_IDLE;
      w_cnt_q <= '0;
      r_st_q  <= R_IDLE;
      r_cnt_q <= '0;
    end else begin
      w_st_q  <= w_st_d;
      w_cnt_q <= w_cnt_d;
      r_st_q  <= r_st_d;
      r_cnt_q <= r_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= OKAY;
    end else begin
      if (aw_take) begin
        awaddr_q  <= s_axil.awaddr;
        aw_held_q <= 1'b1;
      end
      if (w_take) begin
        wdata_q  <= s_axil.wdata;
        wstrb_q  <= s_axil.wstrb;
        w_held_q <= 1'b1;
      end
      if (w_commit) bresp_q <= w_hit ? OKAY : SLVERR;
      if ((w_st_q == W_RESP) && s_axil.bready) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
      end
    end
  end

  // Nonblocking update: a read taken on the commit edge sees old data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_REGS; i++) regs_q[i] <= '0;
    end else if (w_commit && w_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (wstb[b]) regs_q[w_idx][8*b +: 8] <= wdat[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      rresp_q <= OKAY;
    end else if (r_take) begin
      rdata_q <= r_hit ? regs_q[r_idx] : '0;
      rresp_q <= r_hit ? OKAY : SLVERR;
    end
  end

  assign s_axil.awready = (w_st_q == W_IDLE) && !aw_held_q;
  assign s_axil.wready  = (w_st_q == W_IDLE) && !w_held_q;
  assign s_axil.bvalid  = (w_st_q == W_RESP);
  assign s_axil.bresp   = bresp_q;
  assign s_axil.arready = (r_st_q == R_IDLE);
  assign s_axil.rvalid  = (r_st_q == R_RESP);
  assign s_axil.rdata   = rdata_q;
  assign s_axil.rresp   = rresp_q;

  for (genvar i = 0; i < N_REGS; i++) begin : g_out
    assign regs_o[32*i +: 32] = regs_q[i];
  end

endmodule
